// File: rtl/spi_seq_pkg.sv
// Shared types and default widths for the quad-SPI front-end sequencer.
// SPI_SEQ_TIMEOUT_EN adds the default stall limit used by the timeout logic.
package spi_seq_pkg;

  localparam int DEF_ADDR_BITS    = 24;
  localparam int DEF_LEN_BITS     = 8;
  localparam int DEF_GUARD_CYCLES = 2;
`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int DEF_TIMEOUT_CYCLES = 1023;
`endif

  typedef enum logic [2:0] {
    INIT_CMD  = 3'd0,
    INIT_WAIT = 3'd1,
    INIT_STOP = 3'd2,
    IDLE      = 3'd3,
    START     = 3'd4,
    XFER      = 3'd5,
    STOP      = 3'd6,
    GUARD     = 3'd7
  } state_t;

  typedef enum logic {
    CLI_ROM = 1'b0,
    CLI_RAM = 1'b1
  } client_t;

endpackage

// File: rtl/spi_seq_rr_arb.sv
// Two-way round-robin arbiter: on a tie the client that did not win last
// time is chosen. The grant is combinational so the requester's address and
// length are sampled in the same cycle the grant pulse is visible.
module spi_seq_rr_arb
  import spi_seq_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    en_i,
  input  logic    rom_req_i,
  input  logic    ram_req_i,
  input  logic    upd_i,
  input  client_t upd_client_i,
  output logic    gnt_o,
  output client_t gnt_client_o
);

  client_t last_grant_q;

  // Pick a winner among the live requests while the sequencer is idle
  always_comb begin
    gnt_o        = 1'b0;
    gnt_client_o = CLI_ROM;
    if (en_i) begin
      if (rom_req_i && ram_req_i) begin
        gnt_o        = 1'b1;
        gnt_client_o = (last_grant_q == CLI_RAM) ? CLI_ROM : CLI_RAM;
      end else if (rom_req_i) begin
        gnt_o        = 1'b1;
        gnt_client_o = CLI_ROM;
      end else if (ram_req_i) begin
        gnt_o        = 1'b1;
        gnt_client_o = CLI_RAM;
      end
    end
  end

  // Remember who was served last; starts at RAM so ROM wins the first tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= CLI_RAM;
    end else if (upd_i) begin
      last_grant_q <= upd_client_i;
    end
  end

endmodule

// File: rtl/spi_mem_sequencer.sv
// Front-end scheduler for the shared quad-SPI flash/PSRAM controller.
// Enters PSRAM quad mode after reset, then serves the ROM (flash, read-only)
// and RAM (PSRAM, read/write) clients round-robin, one burst at a time.
// Optional macro SPI_SEQ_TIMEOUT_EN adds a stall timeout and the err output.
module spi_mem_sequencer
  import spi_seq_pkg::*;
#(
  parameter int ADDR_BITS    = DEF_ADDR_BITS,
  parameter int LEN_BITS     = DEF_LEN_BITS,
  parameter int GUARD_CYCLES = DEF_GUARD_CYCLES
`ifdef SPI_SEQ_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 init_done,
  input  logic                 rom_req,
  input  logic [ADDR_BITS-1:0] rom_addr,
  input  logic [LEN_BITS-1:0]  rom_len,
  output logic                 rom_gnt,
  output logic [3:0]           rom_rdata,
  output logic                 rom_rvalid,
  output logic                 rom_done,
  input  logic                 ram_req,
  input  logic                 ram_we,
  input  logic [ADDR_BITS-1:0] ram_addr,
  input  logic [LEN_BITS-1:0]  ram_len,
  output logic                 ram_gnt,
  input  logic [3:0]           ram_wdata,
  output logic                 ram_wready,
  output logic [3:0]           ram_rdata,
  output logic                 ram_rvalid,
  output logic                 ram_done,
  output logic                 ctl_select_rom,
  output logic                 ctl_enter_quadmode,
  output logic                 ctl_start_read,
  output logic                 ctl_start_write,
  output logic                 ctl_stop_txn,
  output logic [ADDR_BITS-1:0] ctl_addr,
  output logic [3:0]           ctl_wdata,
  input  logic [3:0]           ctl_rdata,
  input  logic                 ctl_data_ready,
  input  logic                 ctl_data_req,
  input  logic                 ctl_at_quadmode
`ifdef SPI_SEQ_TIMEOUT_EN
  , output logic               err
`endif
);

  localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

  state_t               state_q;
  client_t              client_q;
  logic                 we_q, active_q, init_done_q;
  logic [LEN_BITS-1:0]  len_q;
  logic [LEN_BITS:0]    beat_q, beat_d;
  logic [GW-1:0]        guard_q;
  logic                 sel_rom_q, enter_q, start_rd_q, start_wr_q, stop_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [3:0]           rom_rdata_q, ram_rdata_q;
  logic                 rom_rvalid_q, ram_rvalid_q, rom_done_q, ram_done_q;
  logic                 arb_gnt;
  client_t              arb_client;
  logic                 wr_xfer, rd_xfer, beat, last_beat;

  // A RAM write moves data on data_req; every other burst moves it on data_ready
  assign wr_xfer   = (state_q == XFER) && (client_q == CLI_RAM) && we_q;
  assign rd_xfer   = (state_q == XFER) && !((client_q == CLI_RAM) && we_q);
  assign beat      = (rd_xfer && ctl_data_ready) || (wr_xfer && ctl_data_req);
  assign beat_d    = beat_q + {{LEN_BITS{1'b0}}, 1'b1};
  assign last_beat = beat && (beat_q == {1'b0, len_q});

  spi_seq_rr_arb u_arb (
    .clk          (clk),
    .rst          (rst),
    .en_i         ((state_q == IDLE) && init_done_q),
    .rom_req_i    (rom_req),
    .ram_req_i    (ram_req),
    .upd_i        ((state_q == STOP) && active_q),
    .upd_client_i (client_q),
    .gnt_o        (arb_gnt),
    .gnt_client_o (arb_client)
  );

`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] stall_q;
  logic          timeout, retry_q, err_q;

  assign timeout = ((state_q == INIT_WAIT) || (state_q == XFER)) && !beat &&
                   (stall_q == TW'(TIMEOUT_CYCLES - 1));
  assign err     = err_q;

  // Stall counter runs only while waiting on the controller; any beat or state change clears it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (((state_q != INIT_WAIT) && (state_q != XFER)) || beat) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_q + TW'(1);
    end
  end
`endif

  // Sequencer FSM with registered controller/client outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= INIT_CMD;
      client_q     <= CLI_ROM;
      we_q         <= 1'b0;
      active_q     <= 1'b0;
      init_done_q  <= 1'b0;
      len_q        <= '0;
      beat_q       <= '0;
      guard_q      <= '0;
      sel_rom_q    <= 1'b0;
      enter_q      <= 1'b0;
      start_rd_q   <= 1'b0;
      start_wr_q   <= 1'b0;
      stop_q       <= 1'b1;
      addr_q       <= '0;
      rom_rdata_q  <= '0;
      ram_rdata_q  <= '0;
      rom_rvalid_q <= 1'b0;
      ram_rvalid_q <= 1'b0;
      rom_done_q   <= 1'b0;
      ram_done_q   <= 1'b0;
`ifdef SPI_SEQ_TIMEOUT_EN
      retry_q      <= 1'b0;
      err_q        <= 1'b0;
`endif
    end else begin
      enter_q      <= 1'b0;
      start_rd_q   <= 1'b0;
      start_wr_q   <= 1'b0;
      stop_q       <= 1'b0;
      rom_rvalid_q <= 1'b0;
      ram_rvalid_q <= 1'b0;
      rom_done_q   <= 1'b0;
      ram_done_q   <= 1'b0;
`ifdef SPI_SEQ_TIMEOUT_EN
      err_q        <= 1'b0;
`endif
      case (state_q)
        INIT_CMD: begin
          enter_q   <= 1'b1;
          sel_rom_q <= 1'b0;
          state_q   <= INIT_WAIT;
        end
        INIT_WAIT: begin
          if (ctl_at_quadmode) begin
            stop_q  <= 1'b1;
            state_q <= INIT_STOP;
          end
`ifdef SPI_SEQ_TIMEOUT_EN
          else if (timeout) begin
            stop_q  <= 1'b1;
            err_q   <= 1'b1;
            retry_q <= 1'b1;
            state_q <= STOP;
          end
`endif
        end
        INIT_STOP: begin
          guard_q <= '0;
          state_q <= GUARD;
        end
        IDLE: begin
          if (arb_gnt) begin
            client_q   <= arb_client;
            active_q   <= 1'b1;
            we_q       <= (arb_client == CLI_RAM) && ram_we;
            len_q      <= (arb_client == CLI_ROM) ? rom_len : ram_len;
            addr_q     <= (arb_client == CLI_ROM) ? rom_addr : ram_addr;
            sel_rom_q  <= (arb_client == CLI_ROM);
            start_wr_q <= (arb_client == CLI_RAM) && ram_we;
            start_rd_q <= !((arb_client == CLI_RAM) && ram_we);
            state_q    <= START;
          end
        end
        START: begin
          beat_q  <= '0;
          state_q <= XFER;
        end
        XFER: begin
          if (rd_xfer && ctl_data_ready) begin
            if (client_q == CLI_ROM) begin
              rom_rvalid_q <= 1'b1;
              rom_rdata_q  <= ctl_rdata;
            end else begin
              ram_rvalid_q <= 1'b1;
              ram_rdata_q  <= ctl_rdata;
            end
          end
          if (beat) begin
            beat_q <= beat_d;
          end
          if (last_beat) begin
            stop_q     <= 1'b1;
            rom_done_q <= (client_q == CLI_ROM);
            ram_done_q <= (client_q == CLI_RAM);
            state_q    <= STOP;
          end
`ifdef SPI_SEQ_TIMEOUT_EN
          else if (timeout) begin
            stop_q     <= 1'b1;
            err_q      <= 1'b1;
            rom_done_q <= (client_q == CLI_ROM);
            ram_done_q <= (client_q == CLI_RAM);
            state_q    <= STOP;
          end
`endif
        end
        STOP: begin
          active_q <= 1'b0;
          guard_q  <= '0;
          state_q  <= GUARD;
        end
        GUARD: begin
          if (guard_q == GW'(GUARD_CYCLES - 1)) begin
`ifdef SPI_SEQ_TIMEOUT_EN
            if (retry_q) begin
              retry_q <= 1'b0;
              state_q <= INIT_CMD;
            end else begin
              init_done_q <= 1'b1;
              state_q     <= IDLE;
            end
`else
            init_done_q <= 1'b1;
            state_q     <= IDLE;
`endif
          end else begin
            guard_q <= guard_q + GW'(1);
          end
        end
        default: state_q <= INIT_CMD;
      endcase
    end
  end

  assign init_done          = init_done_q;
  assign rom_gnt            = arb_gnt && (arb_client == CLI_ROM);
  assign ram_gnt            = arb_gnt && (arb_client == CLI_RAM);
  assign rom_rdata          = rom_rdata_q;
  assign rom_rvalid         = rom_rvalid_q;
  assign rom_done           = rom_done_q;
  assign ram_rdata          = ram_rdata_q;
  assign ram_rvalid         = ram_rvalid_q;
  assign ram_done           = ram_done_q;
  assign ram_wready         = wr_xfer && ctl_data_req;
  assign ctl_wdata          = wr_xfer ? ram_wdata : 4'h0;
  assign ctl_select_rom     = sel_rom_q;
  assign ctl_enter_quadmode = enter_q;
  assign ctl_start_read     = start_rd_q;
  assign ctl_start_write    = start_wr_q;
  assign ctl_stop_txn       = stop_q;
  assign ctl_addr           = addr_q;

endmodule

// File: tb/tb_spi_mem_sequencer.sv
// Directed bench for spi_mem_sequencer: quad init, ROM read, RAM write,
// round-robin ordering, long burst, reset mid-burst, optional timeout.
module tb_spi_mem_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        init_done;
  logic        rom_req;
  logic [23:0] rom_addr;
  logic [7:0]  rom_len;
  logic        rom_gnt;
  logic [3:0]  rom_rdata;
  logic        rom_rvalid;
  logic        rom_done;
  logic        ram_req;
  logic        ram_we;
  logic [23:0] ram_addr;
  logic [7:0]  ram_len;
  logic        ram_gnt;
  logic [3:0]  ram_wdata;
  logic        ram_wready;
  logic [3:0]  ram_rdata;
  logic        ram_rvalid;
  logic        ram_done;
  logic        ctl_select_rom;
  logic        ctl_enter_quadmode;
  logic        ctl_start_read;
  logic        ctl_start_write;
  logic        ctl_stop_txn;
  logic [23:0] ctl_addr;
  logic [3:0]  ctl_wdata;
  logic [3:0]  ctl_rdata;
  logic        ctl_data_ready;
  logic        ctl_data_req;
  logic        ctl_at_quadmode;
`ifdef SPI_SEQ_TIMEOUT_EN
  logic        err;
`endif

  spi_mem_sequencer dut (
    .clk(clk), .rst(rst), .init_done(init_done),
    .rom_req(rom_req), .rom_addr(rom_addr), .rom_len(rom_len), .rom_gnt(rom_gnt),
    .rom_rdata(rom_rdata), .rom_rvalid(rom_rvalid), .rom_done(rom_done),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_len(ram_len),
    .ram_gnt(ram_gnt), .ram_wdata(ram_wdata), .ram_wready(ram_wready),
    .ram_rdata(ram_rdata), .ram_rvalid(ram_rvalid), .ram_done(ram_done),
    .ctl_select_rom(ctl_select_rom), .ctl_enter_quadmode(ctl_enter_quadmode),
    .ctl_start_read(ctl_start_read), .ctl_start_write(ctl_start_write),
    .ctl_stop_txn(ctl_stop_txn), .ctl_addr(ctl_addr), .ctl_wdata(ctl_wdata),
    .ctl_rdata(ctl_rdata), .ctl_data_ready(ctl_data_ready),
    .ctl_data_req(ctl_data_req), .ctl_at_quadmode(ctl_at_quadmode)
`ifdef SPI_SEQ_TIMEOUT_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Controller model for quad entry: acknowledge 12 cycles after the enter pulse
  task automatic run_init(input string tag);
    int enter_cnt = 0;
    int stop_cnt = 0;
    int gnt_early = 0;
    int since = 0;
    int lat = -1;
    logic sel_at_enter = 1'b1;
    bit seen = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (ctl_enter_quadmode) begin
        enter_cnt++;
        sel_at_enter = ctl_select_rom;
        seen = 1;
        since = 0;
      end else if (seen) begin
        since++;
      end
      if (ctl_stop_txn) begin
        stop_cnt++;
        ctl_at_quadmode = 1'b0;
      end
      if (seen && since == 12) ctl_at_quadmode = 1'b1;
      #1;
      if (init_done) begin
        lat = since;
        break;
      end
      if (rom_gnt || ram_gnt) gnt_early++;
    end
    check({tag, "_enter_cnt"}, enter_cnt, 1);
    check({tag, "_sel_at_enter"}, sel_at_enter, 0);
    check({tag, "_stop_cnt"}, stop_cnt, 1);
    check({tag, "_gnt_before_init"}, gnt_early, 0);
    check({tag, "_done_latency"}, lat, 16);
    $display("[TB] %s: quad init complete", tag);
  endtask

  // Bounded wait for a grant, starting with the current cycle
  task automatic wait_gnt(input string tag, input bit want_ram);
    bit got = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (want_ram ? ram_gnt : rom_gnt) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    check(tag, got, 1);
  endtask

  int rv_cnt, done_cnt, stop_at_done, widx, wr_cnt, last_done, gcount, gnt_cnt, n;
  bit found;

  initial begin
    rst = 1'b1;
    rom_req = 1'b1; rom_addr = 24'h001000; rom_len = 8'd3;
    ram_req = 1'b0; ram_we = 1'b0; ram_addr = '0; ram_len = '0; ram_wdata = '0;
    ctl_rdata = '0; ctl_data_ready = 1'b0; ctl_data_req = 1'b0; ctl_at_quadmode = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_stop_txn", ctl_stop_txn, 1);
    check("rst_enter", ctl_enter_quadmode, 0);
    check("rst_init_done", init_done, 0);
    check("rst_rom_gnt", rom_gnt, 0);
    check("rst_ctl_addr", ctl_addr, 0);
    rst = 1'b0;
    run_init("init1");

    // ROM read, len 3; controller streams six nibbles A..F
    check("rom_gnt", rom_gnt, 1);
    check("rom_gnt_ram", ram_gnt, 0);
    @(negedge clk);
    rom_req = 1'b0;
    check("rom_start_read", ctl_start_read, 1);
    check("rom_start_write", ctl_start_write, 0);
    check("rom_select", ctl_select_rom, 1);
    check("rom_addr", ctl_addr, 24'h001000);
    rv_cnt = 0; done_cnt = 0; stop_at_done = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (rom_rvalid) begin
        check($sformatf("rom_rdata%0d", rv_cnt), rom_rdata, 32'hA + rv_cnt);
        rv_cnt++;
      end
      if (rom_done) begin
        done_cnt++;
        stop_at_done = ctl_stop_txn;
      end
      ctl_data_ready = (c <= 6);
      ctl_rdata = 4'(9 + c);
    end
    ctl_data_ready = 1'b0;
    check("rom_rvalid_cnt", rv_cnt, 4);
    check("rom_done_cnt", done_cnt, 1);
    check("rom_stop_with_done", stop_at_done, 1);
    $display("[TB] ROM read addr=001000 len=3 beats=%0d", rv_cnt);

    // RAM write, len 7, data 0..7
    ram_req = 1'b1; ram_we = 1'b1; ram_addr = 24'h000040; ram_len = 8'd7;
    wait_gnt("ram_wr_gnt", 1);
    @(negedge clk);
    ram_req = 1'b0;
    check("ram_start_write", ctl_start_write, 1);
    check("ram_start_read", ctl_start_read, 0);
    check("ram_select", ctl_select_rom, 0);
    check("ram_addr", ctl_addr, 24'h000040);
    widx = 0; wr_cnt = 0; done_cnt = 0; last_done = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (ram_done) begin
        done_cnt++;
        last_done = cyc;
        rom_req = 1'b1; rom_len = 8'd0;
        ram_req = 1'b1; ram_we = 1'b0; ram_len = 8'd0;
        break;
      end
      ctl_data_req = (c <= 10);
      ram_wdata = widx[3:0];
      #1;
      if (ram_wready) begin
        check($sformatf("ram_wdata%0d", widx), ctl_wdata, widx);
        widx++;
        wr_cnt++;
      end
    end
    ctl_data_req = 1'b0;
    check("ram_wready_cnt", wr_cnt, 8);
    check("ram_wr_done_cnt", done_cnt, 1);
    $display("[TB] RAM write addr=000040 len=7 beats=%0d", wr_cnt);

    // Both clients requesting: expect ROM, RAM, ROM, RAM with a 3-cycle gap
    ctl_data_ready = 1'b1; ctl_rdata = 4'h5;
    gcount = 0;
    for (int c = 0; c < 80 && gcount < 4; c++) begin
      @(negedge clk);
      if (rom_done || ram_done) last_done = cyc;
      #1;
      if (rom_gnt || ram_gnt) begin
        check($sformatf("rr_ram_gnt%0d", gcount), ram_gnt, gcount % 2);
        check($sformatf("rr_rom_gnt%0d", gcount), rom_gnt, (gcount + 1) % 2);
        check($sformatf("rr_gap%0d", gcount), cyc - last_done, 3);
        $display("[TB] RR grant %0d to %s", gcount, ram_gnt ? "RAM" : "ROM");
        gcount++;
      end
    end
    check("rr_grant_cnt", gcount, 4);
    @(negedge clk);
    rom_req = 1'b0; ram_req = 1'b0;
    found = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ram_done) begin
        found = 1;
        break;
      end
    end
    check("rr_last_done", found, 1);

    // Full-length RAM read (len all-ones); a short ROM request pulse during it is dropped
    ram_req = 1'b1; ram_we = 1'b0; ram_addr = 24'h000100; ram_len = 8'hFF;
    wait_gnt("long_gnt", 1);
    @(negedge clk);
    ram_req = 1'b0;
    rv_cnt = 0; done_cnt = 0; gnt_cnt = 0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (ram_rvalid) rv_cnt++;
      if (ram_done) done_cnt++;
      rom_req = (c == 20 || c == 21);
      #1;
      if (rom_gnt) gnt_cnt++;
    end
    ctl_data_ready = 1'b0;
    check("long_rvalid_cnt", rv_cnt, 256);
    check("long_done_cnt", done_cnt, 1);
    check("dropped_req_gnt", gnt_cnt, 0);
    $display("[TB] RAM read len=255 beats=%0d", rv_cnt);

    // Reset asserted during beat 4 of a RAM write
    ram_req = 1'b1; ram_we = 1'b1; ram_addr = 24'h000080; ram_len = 8'd7;
    wait_gnt("rstw_gnt", 1);
    @(negedge clk);
    ram_req = 1'b0;
    wr_cnt = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      ctl_data_req = 1'b1;
      ram_wdata = 4'(c);
      #1;
      if (ram_wready) wr_cnt++;
      if (wr_cnt == 4) begin
        rst = 1'b1;
        #1;
        break;
      end
    end
    ctl_data_req = 1'b0;
    check("rstw_beats", wr_cnt, 4);
    check("rstw_stop_txn", ctl_stop_txn, 1);
    check("rstw_wready", ram_wready, 0);
    check("rstw_start_write", ctl_start_write, 0);
    check("rstw_init_done", init_done, 0);
    check("rstw_ctl_addr", ctl_addr, 0);
    check("rstw_ctl_wdata", ctl_wdata, 0);
    $display("[TB] reset during RAM write beat %0d", wr_cnt);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_init("init2");

`ifdef SPI_SEQ_TIMEOUT_EN
    // ROM read with a silent controller must time out after 1023 stall cycles
    rom_req = 1'b1; rom_addr = 24'h002000; rom_len = 8'd2;
    wait_gnt("to_gnt", 0);
    @(negedge clk);
    rom_req = 1'b0;
    check("to_start_read", ctl_start_read, 1);
    n = 0; found = 0;
    for (int c = 0; c < 1100; c++) begin
      @(negedge clk);
      if (ctl_stop_txn) begin
        found = 1;
        check("to_err", err, 1);
        check("to_rom_done", rom_done, 1);
        break;
      end
      n++;
    end
    check("to_stop_seen", found, 1);
    check("to_stall_cycles", n, 1023);
    $display("[TB] ROM read timeout after %0d cycles", n);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
